axis_keccak_absorber: RTL and testbench
=======================================

# axis_keccak_absorber

Parametrised AXI-Stream sink that packs message beats into SHA-3 rate blocks, applies pad10*1 with a domain-separation suffix on TLAST, and presents each block to the Keccak permutation core through a valid/ready handshake. It replaces the fixed 16-bit register-accumulation stage behind the AXI-Stream receiver. It adds TREADY backpressure, partial-byte last beats, configurable rate, and automatic extra padding blocks.

## Interface
- DATA_WIDTH, 16, beat width in bits; multiple of 8, divides RATE_BITS
- RATE_BITS, 1088, block size r; multiple of DATA_WIDTH, <= 1600
- DSBYTE, 8'h06, domain suffix byte (8'h1F for SHAKE)
- ACLK  in  1  clock; one clock, all logic on rising edge
- ARESETn  in  1  reset; asynchronous, active-low
- s_tdata  in  DATA_WIDTH  message bytes, byte 0 in bits [7:0]
- s_tkeep  in  DATA_WIDTH/8  byte enables; honoured only on TLAST beat, low-contiguous
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accepted when s_tvalid & s_tready
- s_tlast  in  1  final beat of message
- s_tid  in  2  message ID, sampled on first beat of message
- m_block  out  RATE_BITS  padded/unpadded rate block, byte k at [8k+7:8k]
- m_valid  out  1  block valid
- m_ready  in  1  block consumed when m_valid & m_ready
- m_last  out  1  block is final (padded) block of message
- m_id  out  2  ID of message owning m_block
- msg_cnt  out  32  completed messages (stats)
- blk_cnt  out  32  emitted blocks (stats)

## Operation
- RATE_BYTES = RATE_BITS/8; byte counter bcnt, width $clog2(RATE_BYTES+1).
- States: FILL, EMIT, PADBLK.
- FILL: s_tready=1. Each accepted beat writes its bytes at m_block bytes [bcnt +: DATA_WIDTH/8]. Non-last beats add DATA_WIDTH/8 to bcnt; the last beat adds popcount(s_tkeep). Disabled bytes on the last beat write 0.
- Non-last beat bringing bcnt to RATE_BYTES: go to EMIT, m_last=0, bcnt=0.
- Last beat with final count n < RATE_BYTES: byte n ^= DSBYTE and byte RATE_BYTES-1 ^= 8'h80 (n = RATE_BYTES-1 gives DSBYTE|0x80). Go to EMIT with m_last=1.
- Last beat with n = RATE_BYTES: go to EMIT with m_last=0 and a pending-pad flag set.
- EMIT: m_valid=1, s_tready=0, m_block/m_last/m_id held stable. On m_ready, clear the block to zero.
  - If pad pending: go to PADBLK.
  - Otherwise: go to FILL.
- PADBLK: one cycle to build byte0=DSBYTE, byte RATE_BYTES-1=8'h80, rest 0, m_last=1. Then go to EMIT, pending cleared.
- Zero-byte message: TLAST beat with s_tkeep=0 at bcnt=0 yields a pure pad block.
- s_tid is latched on the first beat after reset or after a TLAST. m_id carries it for all blocks of that message.

## Timing
- Reset values: s_tready=0, m_valid=0, m_last=0, m_id=0, m_block=0, counters=0, state FILL. s_tready rises on the first clock after deassert.
- Latency: m_valid asserts the cycle after the completing or last beat is accepted.
- Block handshake cycle: s_tready stays 0. s_tready returns to 1 the following cycle, giving one bubble per block.
- PADBLK adds one cycle between the two handshakes.
- m_ready may be high before m_valid. No combinational path from m_ready to s_tready.
- Reset mid-message: all partial data, bcnt and pending pad are discarded. The next beat starts a new message at byte 0.

## Configuration
- ABSORB_STATS_EN defined:
  - msg_cnt increments on each m_last block handshake.
  - blk_cnt increments on every block handshake.
  - Both wrap at 2^32.
- Not defined: msg_cnt/blk_cnt are tied to 0 and no counter flops are built.

## Structure
- Package sha3_pkg holds:
  - rate constants SHA3_224/256/384/512_RATE (1152/1088/832/576)
  - DSBYTE_SHA3=8'h06, DSBYTE_SHAKE=8'h1F
  - state enum absorb_state_t {FILL, EMIT, PADBLK}
- Sub-module keccak_pad: combinational; takes block, byte count n and DSBYTE; returns padded block. Used in the FILL last-beat path and PADBLK.

## Test plan
- Empty message, defaults: one beat s_tkeep=2'b00, s_tlast=1 -> single block, byte0=0x06, byte135=0x80, others 0, m_last=1.
- "abc": beats 16'h6261 keep 2'b11, then 16'h0063 keep 2'b01 last -> bytes 61 62 63 06, byte135=0x80, m_last=1; digest through core matches 3a985da7....
- 136-byte message (68 full beats, last tagged) -> block 1 data-only with m_last=0, then pad block (byte0=06, byte135=80) with m_last=1; blk_cnt=2, msg_cnt=1 with ABSORB_STATS_EN.
- 135-byte message (last beat keep 2'b01) -> one block, byte135=0x86, m_last=1.
- Hold m_ready=0 for 10 cycles during EMIT while s_tvalid=1 -> m_block stable, s_tready=0, no beat lost; next message data correct after release.
- Assert ARESETn=0 after 20 bytes of a message with s_tid=2 -> outputs at reset values. A following "abc" with s_tid=1 gives the same block as scenario 2 with m_id=1.

Source files
------------

// File: rtl/sha3_pkg.sv
// sha3_pkg: SHA-3 rate constants, domain-separation bytes and absorber state encoding
package sha3_pkg;
  localparam int SHA3_224_RATE = 1152;
  localparam int SHA3_256_RATE = 1088;
  localparam int SHA3_384_RATE = 832;
  localparam int SHA3_512_RATE = 576;
  localparam logic [7:0] DSBYTE_SHA3 = 8'h06;
  localparam logic [7:0] DSBYTE_SHAKE = 8'h1F;
  typedef enum logic [1:0] {FILL, EMIT, PADBLK} absorb_state_t;
endpackage

// File: rtl/keccak_pad.sv
// keccak_pad: applies pad10*1 with domain suffix ds at byte n and 0x80 at the last rate byte
module keccak_pad #(
  parameter int RATE_BITS = 1088,
  parameter int CW = $clog2(RATE_BITS / 8 + 1)
) (
  input  logic [RATE_BITS-1:0] blk,
  input  logic [CW-1:0]        n,
  input  logic [7:0]           ds,
  output logic [RATE_BITS-1:0] padded
);
  localparam int RB = RATE_BITS / 8;
  for (genvar k = 0; k < RB; k++) begin : g_byte
    assign padded[8*k +: 8] = blk[8*k +: 8] ^ (n == CW'(k) ? ds : 8'h00) ^ (k == RB - 1 ? 8'h80 : 8'h00);
  end
endmodule

// File: rtl/axis_keccak_absorber.sv
// axis_keccak_absorber: packs AXI-Stream beats into padded SHA-3 rate blocks; ABSORB_STATS_EN adds message/block counters
module axis_keccak_absorber
  import sha3_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         RATE_BITS  = SHA3_256_RATE,
  parameter logic [7:0] DSBYTE     = DSBYTE_SHA3
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [1:0]              s_tid,
  output logic [RATE_BITS-1:0]    m_block,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [1:0]              m_id,
  output logic [31:0]             msg_cnt,
  output logic [31:0]             blk_cnt
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int RB  = RATE_BITS / 8;
  localparam int CW  = $clog2(RB + 1);
  localparam int IW  = CW + 3;
  absorb_state_t state, state_n;
  logic [RATE_BITS-1:0] blk, blk_n, wblk, pad_in, padded;
  logic [CW-1:0] bcnt, bcnt_n, pc, n, pad_n;
  logic [IW-1:0] wpos;
  logic [DATA_WIDTH-1:0] md;
  logic rdy, last_r, last_n, pend, pend_n, first, accept, hs;
  logic [1:0] id_r;
  assign accept   = s_tvalid & rdy;
  assign hs       = (state == EMIT) & m_ready;
  assign s_tready = rdy;
  assign m_valid  = state == EMIT;
  assign m_block  = blk;
  assign m_last   = last_r;
  assign m_id     = id_r;
  assign pad_in   = state == PADBLK ? blk : wblk;
  assign pad_n    = state == PADBLK ? '0 : n;
  keccak_pad #(.RATE_BITS(RATE_BITS), .CW(CW)) u_pad (
    .blk(pad_in),
    .n(pad_n),
    .ds(DSBYTE),
    .padded(padded)
  );
  // Merge the incoming beat into the block at bcnt, zeroing disabled bytes of a last beat
  always_comb begin
    pc = '0;
    md = '0;
    for (int j = 0; j < BPB; j++) begin
      pc = pc + CW'(s_tkeep[j]);
      md[8*j +: 8] = (s_tkeep[j] | ~s_tlast) ? s_tdata[8*j +: 8] : 8'h00;
    end
    n = bcnt + (s_tlast ? pc : CW'(BPB));
    wpos = {bcnt, 3'b000};
    wblk = blk;
    wblk[wpos +: DATA_WIDTH] = md;
  end
  // Next-state and next-block decisions for fill, emit and extra pad block
  always_comb begin
    state_n = state;
    blk_n = blk;
    bcnt_n = bcnt;
    last_n = last_r;
    pend_n = pend;
    case (state)
      FILL: if (accept) begin
        if (!s_tlast && n != CW'(RB)) begin
          blk_n = wblk;
          bcnt_n = n;
        end else begin
          state_n = EMIT;
          bcnt_n = '0;
          last_n = s_tlast && n != CW'(RB);
          pend_n = s_tlast && n == CW'(RB);
          blk_n = last_n ? padded : wblk;
        end
      end
      EMIT: if (m_ready) begin
        blk_n = '0;
        last_n = 1'b0;
        state_n = pend ? PADBLK : FILL;
      end
      PADBLK: begin
        blk_n = padded;
        last_n = 1'b1;
        pend_n = 1'b0;
        state_n = EMIT;
      end
      default: state_n = FILL;
    endcase
  end
  // State register; s_tready is registered so m_ready never reaches it combinationally
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= FILL;
      rdy <= 1'b0;
    end else begin
      state <= state_n;
      rdy <= state_n == FILL;
    end
  end
  // Block data, byte count, pad flags and message ID capture
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      blk <= '0;
      bcnt <= '0;
      last_r <= 1'b0;
      pend <= 1'b0;
      first <= 1'b1;
      id_r <= '0;
    end else begin
      blk <= blk_n;
      bcnt <= bcnt_n;
      last_r <= last_n;
      pend <= pend_n;
      if (accept) begin
        if (first) id_r <= s_tid;
        first <= s_tlast;
      end
    end
  end
`ifdef ABSORB_STATS_EN
  logic [31:0] msg_q, blk_q;
  assign msg_cnt = msg_q;
  assign blk_cnt = blk_q;
  // Wrapping counters of completed messages and emitted blocks
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      msg_q <= '0;
      blk_q <= '0;
    end else if (hs) begin
      blk_q <= blk_q + 32'd1;
      msg_q <= msg_q + {31'd0, last_r};
    end
  end
`else
  assign msg_cnt = '0;
  assign blk_cnt = '0;
`endif
endmodule

// File: tb/tb_axis_keccak_absorber.sv
// tb_axis_keccak_absorber: table and scoreboard bench for the AXI-Stream Keccak absorber
module tb_axis_keccak_absorber;
  localparam int DW = 16;
  localparam int RBITS = 1088;
  localparam int RB = RBITS / 8;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [DW/8-1:0] s_tkeep = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [1:0] s_tid = '0;
  logic [RBITS-1:0] m_block;
  logic m_valid, m_ready = 1'b0, m_last;
  logic [1:0] m_id;
  logic [31:0] msg_cnt, blk_cnt;
  typedef struct {logic [RBITS-1:0] blk; logic last; logic [1:0] id;} exp_t;
  typedef struct {int len; logic [1:0] tid; int nblk;} vec_t;
  exp_t sbq[$];
  vec_t vt[8];
  int tests = 0, fails = 0, seen = 0, blk_model = 0, msg_model = 0, ready_mode = 0;
  logic [7:0] msg [0:1023];
  always #5 ACLK = ~ACLK;
  axis_keccak_absorber dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tid(s_tid),
    .m_block(m_block), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_id(m_id),
    .msg_cnt(msg_cnt), .blk_cnt(blk_cnt)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Sink: drive m_ready, compare each block handshake against the scoreboard
  initial forever begin
    exp_t e;
    int k;
    @(negedge ACLK);
    m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m_valid && m_ready) begin
      seen++;
      blk_model++;
      if (m_last) msg_model++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL block: unexpected block, last=%0b id=%0d", m_last, m_id);
      end else begin
        e = sbq.pop_front();
        if (m_block !== e.blk || m_last !== e.last || m_id !== e.id) begin
          fails++;
          k = 0;
          while (k < RB - 1 && m_block[8*k +: 8] === e.blk[8*k +: 8]) k++;
          $display("FAIL block%0d: byte %0d got %02h expected %02h, last got %0b expected %0b, id got %0d expected %0d",
                   seen, k, m_block[8*k +: 8], e.blk[8*k +: 8], m_last, e.last, m_id, e.id);
        end
      end
    end
  end
  task automatic push_model(input int len, input logic [1:0] tid);
    exp_t e;
    int nfull, cnt;
    nfull = len / RB;
    for (int b = 0; b <= nfull; b++) begin
      cnt = b < nfull ? RB : len % RB;
      e.blk = '0;
      for (int k = 0; k < cnt; k++) e.blk[8*k +: 8] = msg[b*RB + k];
      if (b == nfull) begin
        e.blk[8*cnt +: 8] = e.blk[8*cnt +: 8] ^ 8'h06;
        e.blk[8*(RB-1) +: 8] = e.blk[8*(RB-1) +: 8] ^ 8'h80;
      end
      e.last = b == nfull;
      e.id = tid;
      sbq.push_back(e);
    end
  endtask
  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l, input logic [1:0] id);
    int t;
    @(negedge ACLK);
    if ($urandom_range(0, 3) == 0) @(negedge ACLK);
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    s_tid = id;
    s_tvalid = 1'b1;
    t = 0;
    while (!s_tready && t < 500) begin
      @(negedge ACLK);
      t++;
    end
    if (!s_tready) begin
      tests++;
      fails++;
      $display("FAIL beat_accept: s_tready stuck at %0b, required 1", s_tready);
    end
    @(posedge ACLK);
    #1 s_tvalid = 1'b0;
  endtask
  task automatic send_msg(input int len, input logic [1:0] tid);
    int nb, rem;
    logic [1:0] kp;
    logic [15:0] d;
    for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
    push_model(len, tid);
    nb = len == 0 ? 1 : (len + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      rem = len - 2 * b;
      kp = b < nb - 1 ? 2'b11 : rem >= 2 ? 2'b11 : rem == 1 ? 2'b01 : 2'b00;
      d[7:0] = kp[0] ? msg[2*b] : 8'($urandom);
      d[15:8] = kp[1] ? msg[2*b+1] : 8'($urandom);
      send_beat(d, kp, b == nb - 1, b == 0 ? tid : ~tid);
    end
  endtask
  task automatic wait_drain(input string name);
    int t;
    t = 0;
    do begin
      @(negedge ACLK);
      t++;
    end while ((sbq.size() != 0 || m_valid) && t < 3000);
    if (sbq.size() != 0 || m_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_drain: %0d blocks outstanding, required 0", name, sbq.size());
    end
  endtask
  task automatic check_stats(input string name);
`ifdef ABSORB_STATS_EN
    check({name, "_blk_cnt"}, 64'(blk_cnt), 64'(blk_model));
    check({name, "_msg_cnt"}, 64'(msg_cnt), 64'(msg_model));
`else
    check({name, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
    check({name, "_msg_cnt"}, 64'(msg_cnt), 64'd0);
`endif
  endtask
  task automatic check_reset_outputs(input string name);
    check({name, "_tready"}, 64'(s_tready), 64'd0);
    check({name, "_valid"}, 64'(m_valid), 64'd0);
    check({name, "_last"}, 64'(m_last), 64'd0);
    check({name, "_id"}, 64'(m_id), 64'd0);
    check({name, "_block_nonzero"}, 64'(|m_block), 64'd0);
    check({name, "_msg_cnt"}, 64'(msg_cnt), 64'd0);
    check({name, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
  endtask
  task automatic push_abc(input logic [1:0] tid);
    exp_t e;
    e.blk = '0;
    e.blk[31:0] = 32'h06636261;
    e.blk[RBITS-1 -: 8] = 8'h80;
    e.last = 1'b1;
    e.id = tid;
    sbq.push_back(e);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int s0;
    logic st_ok;
    logic [RBITS-1:0] snap;
    vt[0] = '{135, 2'd2, 1};
    vt[1] = '{136, 2'd3, 2};
    vt[2] = '{137, 2'd1, 2};
    vt[3] = '{1, 2'd3, 1};
    vt[4] = '{134, 2'd1, 1};
    vt[5] = '{271, 2'd0, 2};
    vt[6] = '{272, 2'd2, 3};
    vt[7] = '{2, 2'd1, 1};
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("tready_after_reset", 64'(s_tready), 64'd1);
    e.blk = '0;
    e.blk[7:0] = 8'h06;
    e.blk[RBITS-1 -: 8] = 8'h80;
    e.last = 1'b1;
    e.id = 2'd3;
    sbq.push_back(e);
    s0 = seen;
    send_beat(16'hA5C3, 2'b00, 1'b1, 2'd3);
    wait_drain("empty");
    check("empty_nblk", 64'(seen - s0), 64'd1);
    push_abc(2'd1);
    s0 = seen;
    send_beat(16'h6261, 2'b11, 1'b0, 2'd1);
    send_beat(16'hEE63, 2'b01, 1'b1, 2'd0);
    wait_drain("abc");
    check("abc_nblk", 64'(seen - s0), 64'd1);
    ready_mode = 1;
    for (int v = 0; v < 8; v++) begin
      s0 = seen;
      send_msg(vt[v].len, vt[v].tid);
      wait_drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_len%0d_nblk", v, vt[v].len), 64'(seen - s0), 64'(vt[v].nblk));
    end
    check_stats("table");
    ready_mode = 2;
    s0 = seen;
    fork
      begin
        send_msg(3, 2'd2);
        send_msg(4, 2'd1);
      end
      begin
        int t;
        t = 0;
        while (!m_valid && t < 200) begin
          @(negedge ACLK);
          t++;
        end
        check("stall_valid", 64'(m_valid), 64'd1);
        snap = m_block;
        st_ok = 1'b1;
        repeat (10) begin
          @(negedge ACLK);
          st_ok &= (m_block === snap) && !s_tready && m_valid && s_tvalid;
        end
        check("stall_hold", 64'(st_ok), 64'd1);
        ready_mode = 0;
      end
    join
    wait_drain("stall");
    check("stall_nblk", 64'(seen - s0), 64'd2);
    check_stats("stall");
    for (int b = 0; b < 10; b++) send_beat(16'($urandom), 2'b11, 1'b0, b == 0 ? 2'd2 : 2'd1);
    check("mid_id", 64'(m_id), 64'd2);
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    blk_model = 0;
    msg_model = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    push_abc(2'd1);
    s0 = seen;
    send_beat(16'h6261, 2'b11, 1'b0, 2'd1);
    send_beat(16'h0063, 2'b01, 1'b1, 2'd3);
    wait_drain("abc_after_reset");
    check("abc_after_reset_nblk", 64'(seen - s0), 64'd1);
    check_stats("final");
    check("queue_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
